// File: rtl/alu_flag_writeback_if.sv
// Bundle between the issuing stage / register file and the ALU flag-writeback stage.
// The master side drives ALU results and decode; the slave side is the writeback block.
interface alu_flag_writeback_if #(
   parameter int DATA_W  = 16,
   parameter int REG_AW  = 4,
   parameter int STALL_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_c;
   logic              alu_carry;
   logic              alu_low;
   logic              alu_flag;
   logic              alu_zero;
   logic              alu_negative;
   logic [4:0]        flag_mask;
   logic              wr_en;
   logic [REG_AW-1:0] wr_addr;
   logic              psr_load;
   logic [4:0]        psr_load_data;
   logic [4:0]        psr;
   logic              carry_to_alu;
   logic              wb_valid;
   logic              wb_ready;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [STALL_W-1:0] stall_count;

   modport master (
      output in_valid, alu_c, alu_carry, alu_low, alu_flag, alu_zero, alu_negative,
             flag_mask, wr_en, wr_addr, psr_load, psr_load_data, wb_ready,
      input  in_ready, psr, carry_to_alu, wb_valid, wb_addr, wb_data, stall_count
   );

   modport slave (
      input  in_valid, alu_c, alu_carry, alu_low, alu_flag, alu_zero, alu_negative,
             flag_mask, wr_en, wr_addr, psr_load, psr_load_data, wb_ready,
      output in_ready, psr, carry_to_alu, wb_valid, wb_addr, wb_data, stall_count
   );
endinterface

// File: rtl/alu_flag_writeback.sv
// Execute-stage back end: masked PSR flag update, one-entry writeback register with
// valid/ready handshake, carry feedback to the ALU and a saturating stall counter.
module alu_flag_writeback #(
   parameter int DATA_W  = 16,
   parameter int REG_AW  = 4,
   parameter int STALL_W = 16
) (
   input logic               clk,
   input logic               reset,
   alu_flag_writeback_if.slave bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wb_state_t;

   wb_state_t          state;
   wb_state_t          next_state;
   logic               in_ready;
   logic               accept;
   logic               load;
   logic [4:0]         psr_q;
   logic [4:0]         alu_flags;
   logic [REG_AW-1:0]  wb_addr_q;
   logic [DATA_W-1:0]  wb_data_q;
   logic [STALL_W-1:0] stall_q;

   assign in_ready  = (state == EMPTY) | bus.wb_ready;
   assign accept    = bus.in_valid & in_ready;
   assign load      = accept & bus.wr_en;
   assign alu_flags = {bus.alu_carry, bus.alu_low, bus.alu_flag, bus.alu_zero, bus.alu_negative};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // A FULL entry drained this cycle can be replaced by a new load with no bubble.
   always_comb begin
      next_state = state;
      case (state)
         EMPTY: begin
            if (load) next_state = FULL;
         end
         FULL: begin
            if (bus.wb_ready && !load) next_state = EMPTY;
         end
         default: next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else if (load) begin
         wb_addr_q <= bus.wr_addr;
         wb_data_q <= bus.alu_c;
      end
   end

   // Masked-off ALU flags are gated out with AND so an undriven flag never lands in the PSR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psr_q <= '0;
      end else if (bus.psr_load) begin
         psr_q <= bus.psr_load_data;
      end else if (accept) begin
         psr_q <= (bus.flag_mask & alu_flags) | (~bus.flag_mask & psr_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if ((state == FULL) && !bus.wb_ready && (stall_q != {STALL_W{1'b1}})) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.psr          = psr_q;
   assign bus.carry_to_alu = psr_q[4];
   assign bus.wb_valid     = (state == FULL);
   assign bus.wb_addr      = wb_addr_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Directed bench for alu_flag_writeback: reset, writeback handshake, masked flags,
// carry feedback, stall counting with saturation, psr_load priority and async reset.
module tb_alu_flag_writeback;

   logic clk;
   logic reset;
   int   check_count;
   int   fail_count;

   alu_flag_writeback_if #(.DATA_W(16), .REG_AW(4), .STALL_W(16)) bus ();

   alu_flag_writeback #(.DATA_W(16), .REG_AW(4), .STALL_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic wen, input logic [3:0] addr,
                                input logic [15:0] data, input logic [4:0] mask,
                                input logic [4:0] flags);
      bus.in_valid     = valid;
      bus.wr_en        = wen;
      bus.wr_addr      = addr;
      bus.alu_c        = data;
      bus.flag_mask    = mask;
      bus.alu_carry    = flags[4];
      bus.alu_low      = flags[3];
      bus.alu_flag     = flags[2];
      bus.alu_zero     = flags[1];
      bus.alu_negative = flags[0];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      check_count = 0;
      fail_count  = 0;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 5'b00000, 5'b00000);
      bus.psr_load      = 1'b0;
      bus.psr_load_data = 5'b00000;
      bus.wb_ready      = 1'b1;
      #12;
      checkOutput("reset_psr", 32'(bus.psr), 32'h0);
      checkOutput("reset_wb_valid", 32'(bus.wb_valid), 32'h0);
      checkOutput("reset_wb_addr", 32'(bus.wb_addr), 32'h0);
      checkOutput("reset_wb_data", 32'(bus.wb_data), 32'h0);
      checkOutput("reset_stall", 32'(bus.stall_count), 32'h0);
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      reset = 1'b0;

      // Single writeback, one cycle latency, drains next cycle
      applyStimulus(1'b1, 1'b1, 4'd3, 16'h1234, 5'b00000, 5'b00000);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 5'b00000, 5'b00000);
      checkOutput("wb1_valid", 32'(bus.wb_valid), 32'h1);
      checkOutput("wb1_addr", 32'(bus.wb_addr), 32'h3);
      checkOutput("wb1_data", 32'(bus.wb_data), 32'h1234);
      step();
      checkOutput("wb1_drain", 32'(bus.wb_valid), 32'h0);

      // CMP: no writeback, masked flags only, X on masked-off flags
      applyStimulus(1'b1, 1'b0, 4'd1, 16'hdead, 5'b01011, 5'b01001);
      bus.alu_carry = 1'bx;
      bus.alu_flag  = 1'bx;
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 5'b00000, 5'b00000);
      checkOutput("cmp_psr", 32'(bus.psr), 32'h09);
      checkOutput("cmp_no_wb", 32'(bus.wb_valid), 32'h0);
      checkOutput("cmp_wb_data_hold", 32'(bus.wb_data), 32'h1234);

      // ADDU sets carry, ADDCU follows back-to-back
      applyStimulus(1'b1, 1'b1, 4'd5, 16'hffff, 5'b10010, 5'b10000);
      step();
      checkOutput("addu_carry_to_alu", 32'(bus.carry_to_alu), 32'h1);
      checkOutput("addu_psr", 32'(bus.psr), 32'h19);
      checkOutput("addu_wb_data", 32'(bus.wb_data), 32'hffff);
      applyStimulus(1'b1, 1'b1, 4'd6, 16'h0001, 5'b10010, 5'b00000);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 5'b00000, 5'b00000);
      checkOutput("addcu_wb_valid", 32'(bus.wb_valid), 32'h1);
      checkOutput("addcu_wb_addr", 32'(bus.wb_addr), 32'h6);
      checkOutput("addcu_wb_data", 32'(bus.wb_data), 32'h0001);
      checkOutput("addcu_psr", 32'(bus.psr), 32'h09);
      step();
      checkOutput("addcu_drain", 32'(bus.wb_valid), 32'h0);

      // Stall for 5 cycles with a queued operation waiting
      bus.wb_ready = 1'b0;
      applyStimulus(1'b1, 1'b1, 4'd7, 16'habcd, 5'b00000, 5'b00000);
      step();
      applyStimulus(1'b1, 1'b1, 4'd8, 16'h5555, 5'b00000, 5'b00000);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_in_ready", 32'(bus.in_ready), 32'h0);
         checkOutput("stall_wb_data", 32'(bus.wb_data), 32'habcd);
         checkOutput("stall_wb_addr", 32'(bus.wb_addr), 32'h7);
         step();
      end
      checkOutput("stall_count5", 32'(bus.stall_count), 32'h5);
      bus.wb_ready = 1'b1;
      #1;
      checkOutput("unstall_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 5'b00000, 5'b00000);
      checkOutput("queued_wb_valid", 32'(bus.wb_valid), 32'h1);
      checkOutput("queued_wb_addr", 32'(bus.wb_addr), 32'h8);
      checkOutput("queued_wb_data", 32'(bus.wb_data), 32'h5555);
      checkOutput("queued_stall_hold", 32'(bus.stall_count), 32'h5);
      step();
      checkOutput("queued_drain", 32'(bus.wb_valid), 32'h0);

      // psr_load wins over a full-mask accept; writeback still happens
      applyStimulus(1'b1, 1'b1, 4'd9, 16'h0f0f, 5'b11111, 5'b00000);
      bus.psr_load      = 1'b1;
      bus.psr_load_data = 5'b10101;
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 5'b00000, 5'b00000);
      bus.psr_load = 1'b0;
      checkOutput("load_psr", 32'(bus.psr), 32'h15);
      checkOutput("load_carry_to_alu", 32'(bus.carry_to_alu), 32'h1);
      checkOutput("load_wb_valid", 32'(bus.wb_valid), 32'h1);
      checkOutput("load_wb_data", 32'(bus.wb_data), 32'h0f0f);
      step();

      // Long stall past all-ones: counter must saturate, not wrap
      bus.wb_ready = 1'b0;
      applyStimulus(1'b1, 1'b1, 4'd2, 16'h2222, 5'b00000, 5'b00000);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 5'b00000, 5'b00000);
      repeat (65540) step();
      checkOutput("sat_stall", 32'(bus.stall_count), 32'hffff);
      repeat (3) step();
      checkOutput("sat_stall_hold", 32'(bus.stall_count), 32'hffff);
      checkOutput("sat_wb_data", 32'(bus.wb_data), 32'h2222);

      // Asynchronous reset between clock edges
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("areset_wb_valid", 32'(bus.wb_valid), 32'h0);
      checkOutput("areset_psr", 32'(bus.psr), 32'h0);
      checkOutput("areset_stall", 32'(bus.stall_count), 32'h0);
      checkOutput("areset_wb_data", 32'(bus.wb_data), 32'h0);
      step();
      reset = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule

// File: doc/alu_flag_writeback.md
Name: alu_flag_writeback

Overview:
- Execute-stage back end that sits directly downstream of the ALU.
- Captures the ALU result and the five condition outputs (Carry, Low, Flag, Zero, Negative) in the cycle the issuing stage presents them.
- Updates the processor status register (PSR) only for the flags the decoded instruction defines, and holds a register-file writeback in a one-entry output register with a valid/ready handshake.
- Feeds the stored carry back to the ALU carry-in, and counts writeback stall cycles.

Parameters:
- DATA_W, 16, ALU result and writeback data width
- REG_AW, 4, register-file address width
- STALL_W, 16, stall counter width (saturating)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  issuing stage presents a completed ALU operation this cycle
- in_ready  out  1  block accepts the operation this cycle
- alu_c  in  DATA_W  ALU result C
- alu_carry  in  1  ALU Carry
- alu_low  in  1  ALU Low
- alu_flag  in  1  ALU Flag (signed overflow)
- alu_zero  in  1  ALU Zero
- alu_negative  in  1  ALU Negative
- flag_mask  in  5  decoded per-flag update enable {C,L,F,Z,N}
- wr_en  in  1  decoded: operation writes a register (0 for CMP/CMPI/NOP)
- wr_addr  in  REG_AW  destination register
- psr_load  in  1  software load of the PSR
- psr_load_data  in  5  value for psr_load, {C,L,F,Z,N}
- psr  out  5  current PSR {C,L,F,Z,N}
- carry_to_alu  out  1  equals psr[4]; drives the ALU carry-in for the add-with-carry ops
- wb_valid  out  1  writeback pending
- wb_ready  in  1  register file accepts the writeback
- wb_addr  out  REG_AW  writeback register address
- wb_data  out  DATA_W  writeback data
- stall_count  out  STALL_W  cycles with wb_valid=1 and wb_ready=0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: psr=0, wb_valid=0, wb_addr=0, wb_data=0, stall_count=0.
- Accept: accept = in_valid & in_ready. All ALU inputs and decode inputs are sampled only on accept.
- in_ready rule: in_ready = ~wb_valid | wb_ready, combinational pass-through. in_ready does not depend on in_valid.
- Writeback register states: EMPTY (wb_valid=0) and FULL (wb_valid=1).
  - EMPTY, accept with wr_en=1: go FULL next cycle, loading wb_addr=wr_addr and wb_data=alu_c. Latency is 1 cycle.
  - EMPTY, accept with wr_en=0: stay EMPTY. wb_addr and wb_data hold.
  - FULL, wb_ready=0: hold all wb_* outputs; in_ready=0.
  - FULL, wb_ready=1, accept with wr_en=1: stay FULL and load the new entry (back-to-back, no bubble).
  - FULL, wb_ready=1, no accept or wr_en=0: go EMPTY.
- PSR update on accept: for each bit i, psr[i] <= flag_mask[i] ? alu_flag_i : psr[i]. Bits with mask=0 keep their value.
  - A masked-off ALU flag output that is X, or any value, is never captured.
  - The PSR updates on accept even when wr_en=0, so compares update flags.
- Flag timing: the PSR is visible on psr and carry_to_alu in the cycle after accept. An immediately following add-with-carry sees the new carry. Issue must not present it in the same cycle.
- psr_load: psr <= psr_load_data.
  - If psr_load and accept occur in the same cycle, psr_load wins for all five bits.
  - The accepted writeback still proceeds.
- stall_count:
  - Increments each cycle wb_valid=1 and wb_ready=0.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- Reset mid-operation: a pending writeback is discarded with no partial write. The PSR clears.
- Width rule: alu_c is DATA_W wide and passed through unmodified. No sign or zero extension.

Test Plan:
- Reset applied, then released; in_valid=1, wr_en=1, wr_addr=3, alu_c=16'h1234, wb_ready=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=16'h1234. The cycle after, wb_valid=0.
- CMP accept: wr_en=0, flag_mask=5'b01011, alu_low=1, alu_zero=0, alu_negative=1, alu_carry=X, alu_flag=X -> psr=5'b01001, no wb_valid, psr[4] and psr[2] unchanged (0).
- ADDU with alu_carry=1 and mask=5'b10010, then ADDCU next issue -> carry_to_alu=1 in the cycle after the first accept. wb_data of the ADDCU equals the alu_c presented.
- FULL with wb_ready=0 for 5 cycles, in_valid=1 -> in_ready=0 throughout, wb outputs stable, stall_count=5. wb_ready=1 then accepts the queued op that same cycle with no bubble.
- psr_load=1 with psr_load_data=5'b10101 in the same cycle as an accept with mask=5'b11111 and all ALU flags 0 -> psr=5'b10101, and the writeback still appears.
- Force stall_count near all-ones and hold the stall -> count stays at 16'hFFFF. Assert reset asynchronously mid-stall -> wb_valid, psr, and stall_count drop to 0 before the next clk edge.
